ysyx_22041752_dsram_resp: RTL and testbench
===========================================

# ysyx_22041752_dsram_resp

Responder for the core's data SRAM request interface (`data_sram_en/wen/addr/wdata`) issued by the execute stage. It decodes each request into one of three targets: main data RAM, a serial TX FIFO, or a free-running RTC. Read data is returned one cycle later on `data_sram_rdata` for the memory stage. The block sits beside the MEM stage in the simulation top.

## Interface
- `DEPTH`, 1024: RAM size in 64-bit words; must be a power of two.
- `RAM_BASE`, 64'h8000_0000: base byte address of the RAM region.
- `SERIAL_ADDR`, 64'ha000_03f8: serial data register, byte access.
- `RTC_ADDR`, 64'ha000_0048: RTC register, 8-byte read-only.
- `FIFO_DEPTH`, 8: serial TX FIFO entries; must be a power of two.
- `TICK_DIV`, 4: number of clk cycles per RTC increment; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  8  unshifted byte mask: 8'h01/03/0f/ff for store, 8'h00 for load.
- `data_sram_addr`  in  64  byte address.
- `data_sram_wdata`  in  64  store data, LSB-aligned (unshifted).
- `data_sram_rdata`  out  64  load data, LSB-aligned, valid the cycle after the request.
- `access_fault`  out  1  registered; 1 for one cycle after an undecoded or misaligned request.
- `uart_tx_valid`  out  1  FIFO head valid.
- `uart_tx_data`  out  8  FIFO head byte.
- `uart_tx_ready`  in  1  sink accepts the head byte.
- `tx_overflow`  out  1  sticky flag: a serial byte was dropped because the FIFO was full.

## Operation
- Size: `sz` = popcount-class of `wen` for stores (1/2/4/8 bytes). Loads are always treated as 8-byte reads at `{addr[63:3],3'b0}`, shifted right by `8*addr[2:0]`. Zero fill is applied above the shifted bytes. The MEM stage performs sign or zero extension.
- Store lane mask = `wen << addr[2:0]`. Store data = `wdata << 8*addr[2:0]`.
- Misaligned store: `addr[2:0]+sz > 8`. The store is dropped and `access_fault` is set.
- Decode, with the first match winning:
  - RAM: `RAM_BASE ≤ addr < RAM_BASE+8*DEPTH`. Word index is `addr[3+:log2(DEPTH)]`.
  - Serial: `addr == SERIAL_ADDR`.
  - RTC: `{addr[63:3],3'b0} == RTC_ADDR`.
  - Otherwise: fault.
- RAM store writes only the masked bytes.
- Serial store with `wen[0]` pushes `wdata[7:0]` into the FIFO. If the FIFO is full, the byte is dropped and `tx_overflow` is set to 1. Serial load returns `{56'b0, 4'b0, count[3:0]}`, where count is the current FIFO occupancy.
- RTC: 64-bit counter `rtc`. A prescaler counts 0..TICK_DIV-1; `rtc` increments on prescaler wrap. RTC load returns `rtc` as sampled at the request edge. RTC stores are ignored with no fault.
- FIFO:
  - `uart_tx_valid = count != 0`.
  - `uart_tx_data` = byte at the read pointer.
  - Pop happens when `valid && ready`.
  - Pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally.
  - Full when pointers differ only in the MSB.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted and count is unchanged. On an empty FIFO, a push with no pop proceeds normally; the pushed byte becomes visible the next cycle.

## Timing
- Reset values: `data_sram_rdata`=0, `access_fault`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `tx_overflow`=0, FIFO count=0, `rtc`=0, prescaler=0.
- RAM contents are not reset. Verification reads only locations previously written.
- Request sampled at edge N. Store effects (RAM, FIFO, flags) are visible from edge N onward.
- `data_sram_rdata` and `access_fault` are registered at edge N and valid during cycle N+1.
- For a store, or when `en`=0, `data_sram_rdata` is driven to 0 in the next cycle.
- Load in cycle N+1 to an address stored in cycle N returns the new data. No bypass is needed because the write is registered first.
- `access_fault` is a one-cycle pulse and is 0 whenever `en`=0.
- Reset asserted mid-operation: all state listed above returns to its reset value on the next edge. A pending read result is discarded and `rdata` becomes 0.
- RTC increments every TICK_DIV cycles after reset release. With TICK_DIV=4, `rtc` becomes 1 at the 4th edge after reset deasserts.

## Test plan
- Store `wen`=8'h01, addr `RAM_BASE+3`, wdata 0xAB; then load `RAM_BASE+3` → `rdata`=64'hAB next cycle. Load `RAM_BASE` → byte 3 of the result = 0xAB and the other bytes unchanged.
- Store `wen`=8'h0f, addr `RAM_BASE+6` (crosses word boundary) → `access_fault`=1 for one cycle and RAM unchanged. Load addr 0x0 → `access_fault`=1, `rdata`=0.
- With `uart_tx_ready`=0, write 9 bytes 0x41..0x49 to `SERIAL_ADDR` → count=8, `tx_overflow`=1, and a serial load returns 8. Raise ready → bytes 0x41..0x48 are drained in order over 8 cycles, then `uart_tx_valid`=0.
- FIFO full and ready=1, plus a simultaneous push of 0x5A → count stays 8 and 0x5A appears as the last byte drained. `tx_overflow` remains at its previous value.
- TICK_DIV=4: release reset, wait 40 cycles, load `RTC_ADDR` → `rdata`=10. A store to `RTC_ADDR` has no effect and no fault.
- Assert reset for 1 cycle between a load request and its return → `rdata`=0, `uart_tx_valid`=0, `rtc`=0 after reset.

Source files
------------

// File: rtl/ysyx_22041752_dsram_resp.sv
// ysyx_22041752_dsram_resp
// Responder for the core's data SRAM request port. Every request is decoded
// to the main data RAM, the serial TX FIFO or the free-running RTC. Load
// data and the fault flag are registered and returned one cycle after the
// request.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   data_sram_en        request valid this cycle
//   data_sram_wen       unshifted byte mask (01/03/0f/ff store, 00 load)
//   data_sram_addr      byte address
//   data_sram_wdata     LSB-aligned store data
//   data_sram_rdata     LSB-aligned load data, valid the cycle after request
//   access_fault        one-cycle pulse after an undecoded/misaligned request
//   uart_tx_valid/data  FIFO head byte offered to the serial sink
//   uart_tx_ready       sink accepts the head byte
//   tx_overflow         sticky: a serial byte was dropped on a full FIFO
//
// Handshake: uart_tx_valid/uart_tx_data are held stable while valid is high
// and ready is low; a byte transfers (and the FIFO pops) on every clk edge
// where uart_tx_valid && uart_tx_ready. valid never waits on ready.
module ysyx_22041752_dsram_resp #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [63:0] RAM_BASE    = 64'h8000_0000,
    parameter logic [63:0] SERIAL_ADDR = 64'ha000_03f8,
    parameter logic [63:0] RTC_ADDR    = 64'ha000_0048,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TICK_DIV    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [7:0]  data_sram_wen,
    input  logic [63:0] data_sram_addr,
    input  logic [63:0] data_sram_wdata,
    output logic [63:0] data_sram_rdata,
    output logic        access_fault,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    output logic        tx_overflow
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned FW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = FW + 1;
    localparam logic [63:0] RAM_END = RAM_BASE + 64'(DEPTH) * 64'd8;

    // ---------------- request decode ----------------
    logic [2:0]    off;
    logic          is_store;
    logic [3:0]    sz;
    logic [3:0]    end_byte;
    logic          misaligned;
    logic          hit_ram, hit_ser, hit_rtc;
    logic          fault;
    logic          store_ok;
    logic [7:0]    lane;
    logic [63:0]   wshift;
    logic [AW-1:0] ram_idx;

    assign off      = data_sram_addr[2:0];
    assign is_store = data_sram_wen != 8'h00;

    // Access size taken from the highest set bit of the unshifted mask.
    always_comb begin
        sz = 4'd1;
        if (data_sram_wen[7])      sz = 4'd8;
        else if (data_sram_wen[3]) sz = 4'd4;
        else if (data_sram_wen[1]) sz = 4'd2;
    end

    assign end_byte   = {1'b0, off} + sz;
    assign misaligned = is_store && (end_byte > 4'd8);

    // First match wins; the regions are disjoint with the default map, but
    // the priority keeps decode well defined for any parameter choice.
    assign hit_ram = (data_sram_addr >= RAM_BASE) && (data_sram_addr < RAM_END);
    assign hit_ser = !hit_ram && (data_sram_addr == SERIAL_ADDR);
    assign hit_rtc = !hit_ram && !hit_ser && ({data_sram_addr[63:3], 3'b000} == RTC_ADDR);

    assign fault    = data_sram_en && (!(hit_ram || hit_ser || hit_rtc) || misaligned);
    assign store_ok = data_sram_en && is_store && !fault;

    assign lane    = data_sram_wen << off;
    assign wshift  = data_sram_wdata << {off, 3'b000};
    assign ram_idx = data_sram_addr[3 +: AW];

    // ---------------- data RAM (not reset) ----------------
    logic [63:0] mem [DEPTH];
    logic [63:0] ram_merged;

    always_comb begin
        ram_merged = mem[ram_idx];
        for (int b = 0; b < 8; b++) begin
            if (lane[b]) ram_merged[8*b +: 8] = wshift[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (store_ok && hit_ram) mem[ram_idx] <= ram_merged;
    end

    // ---------------- serial TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count;
    logic          full;
    logic          pop, push_req, push;
    logic          tx_overflow_q, tx_overflow_d;

    assign count = wptr_q - rptr_q;
    // Full when the pointers match in index bits but differ in the wrap bit.
    assign full  = (wptr_q ^ rptr_q) == {1'b1, {FW{1'b0}}};

    assign uart_tx_valid = count != '0;
    assign uart_tx_data  = uart_tx_valid ? fifo_mem[rptr_q[FW-1:0]] : 8'h00;

    assign pop      = uart_tx_valid && uart_tx_ready;
    assign push_req = store_ok && hit_ser && data_sram_wen[0];
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    assign push     = push_req && (!full || pop);

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        tx_overflow_d = tx_overflow_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push_req && !push) tx_overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[FW-1:0]] <= data_sram_wdata[7:0];
    end

    assign tx_overflow = tx_overflow_q;

    // ---------------- RTC ----------------
    logic [31:0] presc_q, presc_d;
    logic [63:0] rtc_q, rtc_d;

    always_comb begin
        presc_d = presc_q + 32'd1;
        rtc_d   = rtc_q;
        if (presc_q == 32'(TICK_DIV - 1)) begin
            presc_d = 32'd0;
            rtc_d   = rtc_q + 64'd1;
        end
    end

    // ---------------- read return ----------------
    logic [63:0] raw;
    logic [63:0] rdata_d, rdata_q;
    logic        fault_q;

    always_comb begin
        raw = 64'd0;
        if (hit_ram)      raw = mem[ram_idx];
        else if (hit_ser) raw = {{(64-PW){1'b0}}, count};
        else if (hit_rtc) raw = rtc_q;
    end

    // Stores, idle cycles and faulting loads all return zero.
    assign rdata_d = (data_sram_en && !is_store && !fault) ? (raw >> {off, 3'b000}) : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q       <= 64'd0;
            fault_q       <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            tx_overflow_q <= 1'b0;
            presc_q       <= 32'd0;
            rtc_q         <= 64'd0;
        end else begin
            rdata_q       <= rdata_d;
            fault_q       <= fault;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            tx_overflow_q <= tx_overflow_d;
            presc_q       <= presc_d;
            rtc_q         <= rtc_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign access_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_22041752_dsram_resp.sv
module tb_ysyx_22041752_dsram_resp;

  localparam int unsigned DEPTH       = 1024;
  localparam logic [63:0] RAM_BASE    = 64'h8000_0000;
  localparam logic [63:0] SERIAL_ADDR = 64'ha000_03f8;
  localparam logic [63:0] RTC_ADDR    = 64'ha000_0048;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned TICK_DIV    = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        fault;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_ovf;

  always #5 clk = ~clk;

  ysyx_22041752_dsram_resp #(
    .DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .SERIAL_ADDR(SERIAL_ADDR),
    .RTC_ADDR(RTC_ADDR), .FIFO_DEPTH(FIFO_DEPTH), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_sram_en(en),
    .data_sram_wen(wen),
    .data_sram_addr(addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .access_fault(fault),
    .uart_tx_valid(tx_valid),
    .uart_tx_data(tx_data),
    .uart_tx_ready(tx_ready),
    .tx_overflow(tx_ovf)
  );

  // ---------------- reference model / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [7:0]      ram_m [logic [63:0]];  // byte-addressed RAM image
  logic [7:0]      exp_q[$];              // expected FIFO contents, head first
  logic            exp_ovf = 1'b0;
  longint unsigned edges = 0;             // edges since reset release
  logic [63:0]     exp_rdata = '0;
  logic            exp_fault = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Applies the effect of one clock edge with the current inputs.
  task automatic model_edge();
    int          sz;
    logic [2:0]  off;
    logic [63:0] base;
    logic        in_ram, in_ser, in_rtc, is_st, bad;
    if (reset) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      edges     = 0;
      exp_rdata = '0;
      exp_fault = 1'b0;
      return;
    end
    off   = addr[2:0];
    base  = {addr[63:3], 3'b000};
    is_st = wen != 8'h00;
    case (wen)
      8'h01:   sz = 1;
      8'h03:   sz = 2;
      8'h0f:   sz = 4;
      default: sz = 8;
    endcase
    in_ram = (addr >= RAM_BASE) && (addr < RAM_BASE + 8 * DEPTH);
    in_ser = addr == SERIAL_ADDR;
    in_rtc = base == RTC_ADDR;
    bad    = !(in_ram || in_ser || in_rtc) || (is_st && (int'(off) + sz > 8));
    exp_fault = en && bad;
    exp_rdata = '0;
    if (en && !bad && !is_st) begin
      if (in_ram) begin
        for (int i = 0; i < 8 - int'(off); i++) exp_rdata[8*i +: 8] = ram_m[addr + 64'(i)];
      end else if (in_ser) begin
        exp_rdata = 64'(exp_q.size());
      end else begin
        exp_rdata = 64'(edges / TICK_DIV) >> (8 * off);
      end
    end
    if (tx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (en && !bad && is_st) begin
      if (in_ram) begin
        for (int i = 0; i < sz; i++) ram_m[addr + 64'(i)] = wdata[8*i +: 8];
      end else if (in_ser && wen[0]) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(wdata[7:0]);
        else exp_ovf = 1'b1;
      end
    end
    edges++;
  endtask

  // One clock: model the edge, then compare every output at the negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("rdata", rdata, exp_rdata);
    check("fault", 64'(fault), 64'(exp_fault));
    check("tx_valid", 64'(tx_valid), 64'(exp_q.size() != 0));
    check("tx_data", 64'(tx_data), 64'((exp_q.size() != 0) ? exp_q[0] : 8'h00));
    check("tx_ovf", 64'(tx_ovf), 64'(exp_ovf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
    en = e; wen = w; addr = a; wdata = d;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 64'd0, 64'd0);
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] w, input logic [63:0] d);
    drive(1'b1, w, a, d);
  endtask

  task automatic load(input logic [63:0] a);
    drive(1'b1, 8'h00, a, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] wen_tab [5];

  initial begin
    wen_tab[0] = 8'h00; wen_tab[1] = 8'h01; wen_tab[2] = 8'h03;
    wen_tab[3] = 8'h0f; wen_tab[4] = 8'hff;

    reset = 1'b1; en = 1'b0; wen = '0; addr = '0; wdata = '0; tx_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Seed RAM words used later: word 0 zero, words 1..15 and last random.
    store(RAM_BASE, 8'hff, 64'd0);
    for (int w = 1; w < 16; w++) store(RAM_BASE + 64'(8 * w), 8'hff, {$urandom, $urandom});
    store(RAM_BASE + 64'(8 * (DEPTH - 1)), 8'hff, {$urandom, $urandom});

    // Byte store then loads.
    store(RAM_BASE + 64'd3, 8'h01, 64'hAB);
    load(RAM_BASE + 64'd3);
    check("ab_load", rdata, 64'hAB);
    load(RAM_BASE);
    check("ab_byte3", 64'(rdata[31:24]), 64'hAB);

    // Misaligned store, then confirm the word is unchanged; unmapped load.
    store(RAM_BASE + 64'd6, 8'h0f, 64'hdead_beef);
    check("mis_fault", 64'(fault), 64'd1);
    load(RAM_BASE);
    check("mis_unchanged", rdata, 64'h0000_0000_AB00_0000);
    load(64'd0);
    check("unmapped_fault", 64'(fault), 64'd1);

    // Overfill the FIFO with the sink stalled, then drain.
    for (int i = 0; i < 9; i++) store(SERIAL_ADDR, 8'h01, 64'h41 + 64'(i));
    check("ovf_set", 64'(tx_ovf), 64'd1);
    load(SERIAL_ADDR);
    check("ser_count", rdata, 64'd8);
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) idle();
    check("drained", 64'(tx_valid), 64'd0);

    // Full FIFO with a simultaneous pop and push.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(SERIAL_ADDR, 8'h01, 64'h61 + 64'(i));
    tx_ready = 1'b1;
    store(SERIAL_ADDR, 8'h01, 64'h5A);
    for (int i = 0; i < 9; i++) idle();

    // RTC after 40 idle cycles from reset release.
    tx_ready = 1'b0;
    reset = 1'b1;
    idle();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) idle();
    load(RTC_ADDR);
    check("rtc40", rdata, 64'd10);
    store(RTC_ADDR, 8'hff, 64'h1234);
    check("rtc_store_nofault", 64'(fault), 64'd0);

    // Reset while a load is in flight.
    store(SERIAL_ADDR, 8'h01, 64'h77);
    en = 1'b1; wen = 8'h00; addr = RTC_ADDR; wdata = '0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_rdata", rdata, 64'd0);
    check("rst_valid", 64'(tx_valid), 64'd0);
    load(RTC_ADDR);
    check("rst_rtc", rdata, 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [63:0] a;
      logic [2:0]  o;
      int          w;
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          w = $urandom_range(0, 16);
          if (w == 16) w = DEPTH - 1;
          a = RAM_BASE + 64'(8 * w) + 64'(o);
        end
        3: a = SERIAL_ADDR;
        4: a = RTC_ADDR + 64'(o);
        5: a = 64'($urandom_range(0, 32'hffff));
        6: a = ($urandom_range(0, 1) != 0) ? RAM_BASE + 64'(8 * DEPTH) : RAM_BASE - 64'd1;
        default: a = SERIAL_ADDR + 64'd1;
      endcase
      tx_ready = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 4) != 0, wen_tab[$urandom_range(0, 4)], a, {$urandom, $urandom});
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
